axon_scheduler: RTL and testbench

//  Consumes the per-core spike packet stream that the router delivers for the local core.

---
 rtl/axon_scheduler_if.sv | 30 +++
 rtl/axon_scheduler.sv | 136 +++++++++++++
 tb/tb_axon_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/axon_scheduler_if.sv
// Handshake bundle between the router/neuron core and the axon scheduler:
// the incoming spike packet stream, the global tick and the axon vector
// valid/ready handshake towards the neuron core.
interface axon_scheduler_if #(
   parameter int NUM_AXONS = 256
);
   logic [33:0]          pkt;
   logic                 tick;
   logic [NUM_AXONS-1:0] axons;
   logic                 axons_valid;
   logic                 axons_ready;

   // Scheduler side: consumes packets and ticks, produces the axon vector.
   modport slave (
      input  pkt,
      input  tick,
      input  axons_ready,
      output axons,
      output axons_valid
   );

   // Environment side: router drives packets and ticks, core drives ready.
   modport master (
      output pkt,
      output tick,
      output axons_ready,
      input  axons,
      input  axons_valid
   );
endinterface

// File: rtl/axon_scheduler.sv
// Axon scheduler: stores incoming spikes in a circular delay buffer of axon
// bit-vectors indexed by future tick, and on each global tick hands the due
// vector to the neuron core over a valid/ready handshake, then clears it.
module axon_scheduler #(
   parameter int NUM_AXONS = 256,
   parameter int DEPTH     = 16
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [1:0]      core_id_i,
   axon_scheduler_if.slave bus,
   output logic [7:0]      drop_count_o,
   output logic            tick_overrun_o
);
   localparam int AW = $clog2(NUM_AXONS);
   localparam int DW = $clog2(DEPTH);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_e;

   state_e               state_q;
   logic [DW-1:0]        rd_ptr_q;
   logic                 tick_pending_q;
   logic                 tick_overrun_q;
   logic [7:0]           drop_count_q;
   logic [NUM_AXONS-1:0] axons_q;
   logic                 axons_valid_q;

   logic [NUM_AXONS-1:0] slots_q [DEPTH];
   logic [NUM_AXONS-1:0] slots_d [DEPTH];

   logic                 pkt_valid_s;
   logic                 pkt_mine_s;
   logic [DW-1:0]        base_s;
   logic [DW-1:0]        wr_slot_s;
   logic [AW-1:0]        axon_idx_s;
   logic                 hs_s;

   // Decode the packet and compute the next contents of every delay slot.
   always_comb begin
      pkt_valid_s = (bus.pkt != 34'd0);
      pkt_mine_s  = pkt_valid_s && (bus.pkt[33:32] == core_id_i);
      axon_idx_s  = bus.pkt[20 +: AW];
      // While emitting, delays count from the next slot so the slot being
      // handed out is never written.
      if (state_q == ST_EMIT) begin
         base_s = rd_ptr_q + DW'(1);
      end else begin
         base_s = rd_ptr_q;
      end
      wr_slot_s = base_s + bus.pkt[28 +: DW];
      hs_s      = (state_q == ST_EMIT) && axons_valid_q && bus.axons_ready;
      for (int i = 0; i < DEPTH; i++) begin
         if (hs_s && (DW'(i) == rd_ptr_q)) begin
            slots_d[i] = {NUM_AXONS{1'b0}};
         end else begin
            slots_d[i] = slots_q[i];
         end
         if (pkt_mine_s && (DW'(i) == wr_slot_s)) begin
            slots_d[i][axon_idx_s] = 1'b1;
         end else begin
            slots_d[i][axon_idx_s] = slots_d[i][axon_idx_s];
         end
      end
   end

   // Delay buffer storage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            slots_q[i] <= {NUM_AXONS{1'b0}};
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            slots_q[i] <= slots_d[i];
         end
      end
   end

   // Emit FSM with read pointer, tick bookkeeping and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= ST_IDLE;
         rd_ptr_q       <= {DW{1'b0}};
         tick_pending_q <= 1'b0;
         tick_overrun_q <= 1'b0;
         drop_count_q   <= 8'd0;
         axons_q        <= {NUM_AXONS{1'b0}};
         axons_valid_q  <= 1'b0;
      end else begin
         if (pkt_valid_s && !pkt_mine_s && (drop_count_q != 8'hFF)) begin
            drop_count_q <= drop_count_q + 8'd1;
         end
         case (state_q)
            ST_IDLE: begin
               if (bus.tick || tick_pending_q) begin
                  state_q        <= ST_EMIT;
                  // Use next-state contents so a zero-delay spike arriving
                  // with the tick is part of this emission.
                  axons_q        <= slots_d[rd_ptr_q];
                  axons_valid_q  <= 1'b1;
                  tick_pending_q <= 1'b0;
                  if (bus.tick && tick_pending_q) begin
                     tick_overrun_q <= 1'b1;
                  end
               end
            end
            ST_EMIT: begin
               if (bus.tick) begin
                  if (tick_pending_q) begin
                     tick_overrun_q <= 1'b1;
                  end else begin
                     tick_pending_q <= 1'b1;
                  end
               end
               if (hs_s) begin
                  state_q       <= ST_IDLE;
                  axons_valid_q <= 1'b0;
                  rd_ptr_q      <= rd_ptr_q + DW'(1);
               end
            end
            default: begin
               state_q       <= ST_IDLE;
               axons_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.axons       = axons_q;
   assign bus.axons_valid = axons_valid_q;
   assign drop_count_o    = drop_count_q;
   assign tick_overrun_o  = tick_overrun_q;
endmodule

// File: tb/tb_axon_scheduler.sv
// Self-checking bench for axon_scheduler: directed scenarios followed by
// random traffic, all compared against a reference model that tracks spikes
// by the index of the emission they belong to.
module tb_axon_scheduler;
   localparam int NA = 256;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    core_id;
   logic [7:0]    drop_count;
   logic          tick_overrun;

   axon_scheduler_if #(.NUM_AXONS(NA)) bus_if ();

   axon_scheduler #(.NUM_AXONS(NA), .DEPTH(16)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .core_id_i      (core_id),
      .bus            (bus_if),
      .drop_count_o   (drop_count),
      .tick_overrun_o (tick_overrun)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state.
   logic [NA-1:0] sched [int];
   int            m_begun;
   logic          m_busy;
   logic          m_pending;
   logic          m_ovr;
   int            m_drop;
   logic [NA-1:0] m_axons;
   int            hs_count;

   task automatic chk(input string tag, input logic [NA-1:0] obs, input logic [NA-1:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_reset();
      sched.delete();
      m_begun   = 0;
      m_busy    = 1'b0;
      m_pending = 1'b0;
      m_ovr     = 1'b0;
      m_drop    = 0;
      m_axons   = '0;
   endtask

   task automatic model(input logic [33:0] pkt, input logic tk, input logic rdy);
      int            tgt;
      logic [NA-1:0] v;
      if (pkt != 34'd0) begin
         if (pkt[33:32] == core_id) begin
            tgt = m_begun + int'(pkt[31:28]);
            v = sched.exists(tgt) ? sched[tgt] : '0;
            v[pkt[27:20]] = 1'b1;
            sched[tgt] = v;
         end else if (m_drop < 255) begin
            m_drop++;
         end
      end
      if (!m_busy) begin
         if (tk || m_pending) begin
            m_axons = sched.exists(m_begun) ? sched[m_begun] : '0;
            sched.delete(m_begun);
            m_begun++;
            m_busy = 1'b1;
            if (tk && m_pending) m_ovr = 1'b1;
            m_pending = 1'b0;
         end
      end else begin
         if (tk) begin
            if (m_pending) m_ovr = 1'b1;
            else m_pending = 1'b1;
         end
         if (rdy) m_busy = 1'b0;
      end
   endtask

   task automatic check_outputs();
      chk("valid", NA'(bus_if.axons_valid), NA'(m_busy));
      if (m_busy) chk("axons", bus_if.axons, m_axons);
      chk("drop_count", NA'(drop_count), NA'(m_drop));
      chk("tick_overrun", NA'(tick_overrun), NA'(m_ovr));
   endtask

   task automatic step(input logic [33:0] pkt, input logic tk, input logic rdy);
      bus_if.pkt         = pkt;
      bus_if.tick        = tk;
      bus_if.axons_ready = rdy;
      if (bus_if.axons_valid && rdy) hs_count++;
      model(pkt, tk, rdy);
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   function automatic logic [33:0] mkpkt(input logic [1:0] dst, input logic [3:0] d, input logic [7:0] a);
      return {dst, d, a, 20'd0};
   endfunction

   task automatic do_reset(input logic [1:0] cid);
      rst_n = 1'b0;
      bus_if.pkt = 34'd0;
      bus_if.tick = 1'b0;
      bus_if.axons_ready = 1'b0;
      #1;
      model_reset();
      chk("rst_valid", NA'(bus_if.axons_valid), NA'(1'b0));
      chk("rst_axons", bus_if.axons, '0);
      chk("rst_drop", NA'(drop_count), '0);
      chk("rst_ovr", NA'(tick_overrun), '0);
      core_id = cid;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [NA-1:0] expv;
      logic [NA-1:0] got;
      logic [33:0]   rp;

      core_id = 2'd1;
      hs_count = 0;
      do_reset(2'd1);

      // 1: spike at delay 2 appears on the third tick only.
      step(mkpkt(2'd1, 4'd2, 8'd5), 1'b0, 1'b1);
      for (int t = 1; t <= 3; t++) begin
         step(34'd0, 1'b1, 1'b1);
         got = bus_if.axons;
         expv = '0;
         if (t == 3) expv[5] = 1'b1;
         chk($sformatf("t1_tick%0d", t), got, expv);
         step(34'd0, 1'b0, 1'b1);
      end

      // 2: misaddressed packets are counted and saturate.
      step(mkpkt(2'd2, 4'd1, 8'd3), 1'b0, 1'b1);
      chk("t2_drop1", NA'(drop_count), NA'(8'd1));
      for (int i = 0; i < 299; i++) step(mkpkt(2'd2, 4'd1, 8'd3), 1'b0, 1'b1);
      chk("t2_drop_sat", NA'(drop_count), NA'(8'd255));
      step(34'd0, 1'b1, 1'b1);
      chk("t2_nothing", bus_if.axons, '0);
      step(34'd0, 1'b0, 1'b1);

      // 3: stalled emission stays stable; spike arriving meanwhile is next tick.
      step(34'd0, 1'b1, 1'b0);
      step(mkpkt(2'd1, 4'd0, 8'd7), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(34'd0, 1'b0, 1'b0);
      chk("t3_stable", bus_if.axons, '0);
      step(34'd0, 1'b0, 1'b1);
      step(34'd0, 1'b1, 1'b1);
      expv = '0;
      expv[7] = 1'b1;
      chk("t3_next", bus_if.axons, expv);
      step(34'd0, 1'b0, 1'b1);

      // 4: write across the buffer wrap point.
      do_reset(2'd1);
      for (int i = 0; i < 15; i++) begin
         step(34'd0, 1'b1, 1'b1);
         step(34'd0, 1'b0, 1'b1);
      end
      step(mkpkt(2'd1, 4'd3, 8'd9), 1'b0, 1'b1);
      for (int t = 1; t <= 4; t++) begin
         step(34'd0, 1'b1, 1'b1);
         got = bus_if.axons;
         step(34'd0, 1'b0, 1'b1);
      end
      expv = '0;
      expv[9] = 1'b1;
      chk("t4_wrap", got, expv);

      // 5: two ticks during a stall set pending then overrun.
      step(34'd0, 1'b1, 1'b0);
      step(34'd0, 1'b1, 1'b0);
      step(34'd0, 1'b0, 1'b0);
      step(34'd0, 1'b1, 1'b0);
      chk("t5_overrun", NA'(tick_overrun), NA'(1'b1));
      hs_count = 0;
      for (int i = 0; i < 6; i++) step(34'd0, 1'b0, 1'b1);
      chk("t5_emissions", NA'(hs_count), NA'(2));

      // 6: reset in the middle of an emission with populated slots.
      for (int d = 1; d <= 5; d++) step(mkpkt(2'd1, 4'(d), 8'(d * 11)), 1'b0, 1'b1);
      step(mkpkt(2'd1, 4'd0, 8'd200), 1'b1, 1'b0);
      step(34'd0, 1'b0, 1'b0);
      do_reset(2'd1);
      for (int t = 0; t < 6; t++) begin
         step(34'd0, 1'b1, 1'b1);
         chk("t6_zero", bus_if.axons, '0);
         step(34'd0, 1'b0, 1'b1);
      end

      // Random traffic against the model.
      do_reset(2'd2);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            rp = 34'd0;
         end else begin
            rp = {32'($urandom), 2'($urandom)};
            rp[33:32] = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'd2;
            rp[31:28] = 4'($urandom_range(0, 14));
         end
         step(rp, ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) < 7));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
